scan_chain_programmer: RTL and testbench

Upstream loader for `accumulator_microcontroller`. It accepts program/state bytes over a valid/ready byte port and shifts them serially into the microcontroller scan chain. At the same time it captures the bits leaving the chain and returns them as readback bytes. Once the whole chain is loaded, it releases the processor by raising `mcu_proc_en` and waits for `mcu_halt`. It drives the microcontroller's `scan_enable`, `scan_in` and `proc_en`, and consumes its `scan_out` and `halt`.

---
 rtl/scan_chain_programmer_if.sv | 21 ++
 rtl/scan_chain_programmer.sv | 141 ++++++++++++++
 tb/tb_scan_chain_programmer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_programmer_if.sv
// Byte-stream port of the scan-chain loader: start pulse, write bytes in, readback bytes out.
// The master side is the upstream host; the slave side is scan_chain_programmer.
interface scan_chain_programmer_if;
    logic       start;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport master (
        output start, wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_data, rd_valid
    );

    modport slave (
        input  start, wr_data, wr_valid, rd_ready,
        output wr_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/scan_chain_programmer.sv
// Loads bytes MSB-first into the microcontroller scan chain, returns the displaced bits as
// readback bytes, then releases the processor and waits for it to halt.
module scan_chain_programmer #(
    parameter int CHAIN_LEN = 280
) (
    input  logic                    clk,
    input  logic                    rst_n,
    scan_chain_programmer_if.slave  host,
    output logic                    sc_scan_enable,
    output logic                    sc_scan_in,
    input  logic                    sc_scan_out,
    output logic                    mcu_proc_en,
    input  logic                    mcu_halt,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DRAIN,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [9:0] LEN = 10'(CHAIN_LEN);

    state_t     state_q, state_d;
    logic [9:0] rem_q, rem_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       scan_in_q, scan_in_d;
    logic       scan_en_q, scan_en_d;
    logic       wr_ready_q, wr_ready_d;
    logic       rd_valid_q, rd_valid_d;
    logic       proc_en_q, proc_en_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        cap_d     = cap_q;
        rd_data_d = rd_data_q;
        scan_in_d = 1'b0;

        case (state_q)
            S_IDLE, S_RUN, S_DONE: begin
                if (host.start) begin
                    state_d = S_LOAD;
                    rem_d   = LEN;
                end else if (state_q == S_RUN && mcu_halt) begin
                    state_d = S_DONE;
                end
            end
            S_LOAD: begin
                if (host.start) begin
                    rem_d = LEN;
                end else if (host.wr_valid) begin
                    // First bit goes out on the cycle after acceptance, so it is presented now
                    scan_in_d = host.wr_data[7];
                    sh_d      = {host.wr_data[6:0], 1'b0};
                    cap_d     = 8'h00;
                    cnt_d     = (rem_q >= 10'd8) ? 4'd8 : rem_q[3:0];
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                cap_d = {cap_q[6:0], sc_scan_out};
                sh_d  = {sh_q[6:0], 1'b0};
                rem_d = rem_q - 10'd1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rd_data_d = {cap_q[6:0], sc_scan_out};
                    state_d   = S_DRAIN;
                end else begin
                    scan_in_d = sh_q[7];
                end
            end
            S_DRAIN: begin
                if (host.rd_ready) begin
                    state_d = (rem_q != 10'd0) ? S_LOAD : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop
        wr_ready_d = (state_d == S_LOAD);
        rd_valid_d = (state_d == S_DRAIN);
        scan_en_d  = (state_d == S_SHIFT);
        proc_en_d  = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rem_q      <= LEN;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            cap_q      <= 8'h00;
            rd_data_q  <= 8'h00;
            scan_in_q  <= 1'b0;
            scan_en_q  <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            proc_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            cap_q      <= cap_d;
            rd_data_q  <= rd_data_d;
            scan_in_q  <= scan_in_d;
            scan_en_q  <= scan_en_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            proc_en_q  <= proc_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign host.wr_ready  = wr_ready_q;
    assign host.rd_valid  = rd_valid_q;
    assign host.rd_data   = rd_data_q;
    assign sc_scan_enable = scan_en_q;
    assign sc_scan_in     = scan_in_q;
    assign mcu_proc_en    = proc_en_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_scan_chain_programmer.sv
// Bench for scan_chain_programmer: a 16-bit and a 12-bit chain instance, each driving a
// behavioural scan-chain stand-in, checked against a bit-stream reference model.
module tb_scan_chain_programmer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        start;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        rd_ready;
    logic        halt;
    logic        pre_ld;
    logic [15:0] pre_val;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    scan_chain_programmer_if a_if();
    scan_chain_programmer_if b_if();

    assign a_if.start    = start & ~sel;
    assign a_if.wr_data  = wr_data;
    assign a_if.wr_valid = wr_valid & ~sel;
    assign a_if.rd_ready = rd_ready & ~sel;
    assign b_if.start    = start & sel;
    assign b_if.wr_data  = wr_data;
    assign b_if.wr_valid = wr_valid & sel;
    assign b_if.rd_ready = rd_ready & sel;

    logic sc_en_a, sc_in_a, sc_out_a, pe_a, busy_a, done_a;
    logic sc_en_b, sc_in_b, sc_out_b, pe_b, busy_b, done_b;

    scan_chain_programmer #(.CHAIN_LEN(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .host(a_if),
        .sc_scan_enable(sc_en_a), .sc_scan_in(sc_in_a), .sc_scan_out(sc_out_a),
        .mcu_proc_en(pe_a), .mcu_halt(halt), .busy(busy_a), .done(done_a)
    );

    scan_chain_programmer #(.CHAIN_LEN(12)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .host(b_if),
        .sc_scan_enable(sc_en_b), .sc_scan_in(sc_in_b), .sc_scan_out(sc_out_b),
        .mcu_proc_en(pe_b), .mcu_halt(halt), .busy(busy_b), .done(done_b)
    );

    // Microcontroller scan-chain stand-ins: shift toward scan_out at the MSB
    logic [15:0] chain_a;
    logic [11:0] chain_b;
    always @(posedge clk) begin
        if (pre_ld && !sel)  chain_a <= pre_val;
        else if (sc_en_a)    chain_a <= {chain_a[14:0], sc_in_a};
        if (pre_ld && sel)   chain_b <= pre_val[11:0];
        else if (sc_en_b)    chain_b <= {chain_b[10:0], sc_in_b};
    end
    assign sc_out_a = chain_a[15];
    assign sc_out_b = chain_b[11];

    logic        o_wr_ready, o_rd_valid, o_sc_en, o_pe, o_busy, o_done;
    logic [7:0]  o_rd_data;
    logic [15:0] o_chain;
    logic [14:0] outs_a;
    assign o_wr_ready = sel ? b_if.wr_ready : a_if.wr_ready;
    assign o_rd_valid = sel ? b_if.rd_valid : a_if.rd_valid;
    assign o_rd_data  = sel ? b_if.rd_data  : a_if.rd_data;
    assign o_sc_en    = sel ? sc_en_b : sc_en_a;
    assign o_pe       = sel ? pe_b    : pe_a;
    assign o_busy     = sel ? busy_b  : busy_a;
    assign o_done     = sel ? done_b  : done_a;
    assign o_chain    = sel ? {4'h0, chain_b} : chain_a;
    assign outs_a = {a_if.wr_ready, a_if.rd_valid, a_if.rd_data, sc_en_a, sc_in_a, pe_a, busy_a, done_a};

    // Whole-session reference: chain ends holding the first L bits sent; readback is the old chain, MSB first
    function automatic void ref_session(input int L, input logic [15:0] pre,
                                        input logic [7:0] b0, input logic [7:0] b1,
                                        output logic [7:0] r0, output logic [7:0] r1,
                                        output logic [15:0] fin);
        logic [7:0] byt;
        r0 = 8'h00; r1 = 8'h00; fin = 16'h0000;
        for (int i = 0; i < L; i++) begin
            byt = (i < 8) ? b0 : b1;
            fin = {fin[14:0], byt[7 - (i % 8)]};
            if (i < 8) r0 = {r0[6:0], pre[L - 1 - i]};
            else       r1 = {r1[6:0], pre[L - 1 - i]};
        end
    endfunction

    task automatic preload(input logic [15:0] v);
        pre_val = v; pre_ld = 1'b1;
        @(negedge clk);
        pre_ld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int start_at,
                             output int en, output int acc, output bit ok);
        int n;
        ok = 1'b1; en = 0; wr_data = b; wr_valid = 1'b1; n = 0;
        while (!o_wr_ready && n < 50) begin @(negedge clk); n++; end
        if (!o_wr_ready) ok = 1'b0;
        acc = cyc;
        @(negedge clk);
        wr_valid = 1'b0;
        n = 0;
        while (!o_rd_valid && n < 50) begin
            if (o_sc_en) en++;
            start = (n == start_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (!o_rd_valid) ok = 1'b0;
    endtask

    task automatic pop_byte(input int stall, output logic [7:0] rd);
        rd_ready = 1'b0;
        repeat (stall) @(negedge clk);
        rd = o_rd_data;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        int en, acc; bit ok;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (outs_a !== 15'h0) begin bad++; $display("FAIL reset_outs: got %h want %h", outs_a, 15'h0); end
        rst_n = 1'b1;
        preload(16'h5555);
        pulse_start();
        wr_data = 8'hFF; wr_valid = 1'b1;
        en = 0;
        while (!o_wr_ready && en < 50) begin @(negedge clk); en++; end
        @(negedge clk);
        wr_valid = 1'b0;
        total++; if (o_sc_en !== 1'b1) begin bad++; $display("FAIL shift_entered: got %b want 1", o_sc_en); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (outs_a !== 15'h0) begin bad++; $display("FAIL async_reset_outs: got %h want %h", outs_a, 15'h0); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({o_wr_ready, o_busy, o_sc_en} !== 3'b000) begin
                bad++; $display("FAIL idle_after_reset: got %b want 000", {o_wr_ready, o_busy, o_sc_en});
            end
        end
        acc = 0; ok = 1'b1;
    endtask

    task automatic test_full_load();
        int en0, en1, acc0, acc1; bit ok0, ok1;
        logic [7:0] r0, r1;
        sel = 1'b0;
        preload(16'hBEEF);
        pulse_start();
        total++; if ({o_wr_ready, o_busy} !== 2'b11) begin bad++; $display("FAIL load_entered: got %b want 11", {o_wr_ready, o_busy}); end
        push_byte(8'h12, -1, en0, acc0, ok0);
        pop_byte(0, r0);
        push_byte(8'h34, -1, en1, acc1, ok1);
        total++; if (o_pe !== 1'b0) begin bad++; $display("FAIL proc_en_early: got %b want 0", o_pe); end
        pop_byte(0, r1);
        total++; if ((ok0 & ok1) !== 1'b1) begin bad++; $display("FAIL full_handshake: got %b want 1", ok0 & ok1); end
        total++; if (en0 + en1 != 16) begin bad++; $display("FAIL full_shift_cycles: got %0d want 16", en0 + en1); end
        total++; if (r0 !== 8'hBE) begin bad++; $display("FAIL full_rd0: got %h want be", r0); end
        total++; if (r1 !== 8'hEF) begin bad++; $display("FAIL full_rd1: got %h want ef", r1); end
        total++; if (o_chain !== 16'h1234) begin bad++; $display("FAIL full_chain: got %h want 1234", o_chain); end
        total++; if (acc1 - acc0 != 10) begin bad++; $display("FAIL byte_period: got %0d want 10", acc1 - acc0); end
        total++; if (o_pe !== 1'b1) begin bad++; $display("FAIL proc_en_rise: got %b want 1", o_pe); end
    endtask

    task automatic test_partial();
        int en0, en1, acc; bit ok;
        logic [7:0] r0, r1;
        sel = 1'b1;
        preload(16'h0ABC);
        pulse_start();
        push_byte(8'hF0, -1, en0, acc, ok);
        pop_byte(0, r0);
        push_byte(8'hA5, -1, en1, acc, ok);
        pop_byte(0, r1);
        total++; if (en0 != 8) begin bad++; $display("FAIL partial_en0: got %0d want 8", en0); end
        total++; if (en1 != 4) begin bad++; $display("FAIL partial_en1: got %0d want 4", en1); end
        total++; if (r0 !== 8'hAB) begin bad++; $display("FAIL partial_rd0: got %h want ab", r0); end
        total++; if (r1 !== 8'h0C) begin bad++; $display("FAIL partial_rd1: got %h want 0c", r1); end
        total++; if (o_chain !== 16'h0F0A) begin bad++; $display("FAIL partial_chain: got %h want 0f0a", o_chain); end
        total++; if (o_pe !== 1'b1) begin bad++; $display("FAIL partial_run: got %b want 1", o_pe); end
    endtask

    task automatic test_backpressure();
        int en, acc; bit ok;
        logic [15:0] v;
        logic [7:0]  b0, b1, r;
        sel = 1'b0;
        v = 16'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
        preload(v);
        pulse_start();
        push_byte(b0, -1, en, acc, ok);
        repeat (20) begin
            total++;
            if ({o_rd_valid, o_rd_data, o_sc_en, o_wr_ready} !== {1'b1, v[15:8], 2'b00}) begin
                bad++; $display("FAIL stall_hold: got %h want %h", {o_rd_valid, o_rd_data, o_sc_en, o_wr_ready}, {1'b1, v[15:8], 2'b00});
            end
            @(negedge clk);
        end
        total++; if (o_chain !== {v[7:0], b0}) begin bad++; $display("FAIL stall_chain: got %h want %h", o_chain, {v[7:0], b0}); end
        pop_byte(0, r);
        push_byte(b1, -1, en, acc, ok);
        pop_byte(0, r);
        total++; if (r !== v[7:0]) begin bad++; $display("FAIL resume_rd: got %h want %h", r, v[7:0]); end
        total++; if (o_chain !== {b0, b1}) begin bad++; $display("FAIL resume_chain: got %h want %h", o_chain, {b0, b1}); end
    endtask

    task automatic test_run_halt();
        sel = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({o_pe, o_sc_en, o_done} !== 3'b100) begin bad++; $display("FAIL run_state: got %b want 100", {o_pe, o_sc_en, o_done}); end
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        total++; if ({o_pe, o_done, o_busy} !== 3'b010) begin bad++; $display("FAIL halt_done: got %b want 010", {o_pe, o_done, o_busy}); end
        repeat (3) @(negedge clk);
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL done_hold: got %b want 1", o_done); end
        pulse_start();
        total++; if ({o_wr_ready, o_done, o_busy} !== 3'b101) begin bad++; $display("FAIL done_restart: got %b want 101", {o_wr_ready, o_done, o_busy}); end
    endtask

    task automatic test_restart();
        int en0, en1, acc; bit ok;
        logic [7:0] r0, r1;
        sel = 1'b0;
        preload(16'hC3A5);
        push_byte(8'h5A, 3, en0, acc, ok);
        pop_byte(0, r0);
        total++; if (en0 != 8) begin bad++; $display("FAIL start_in_shift_en: got %0d want 8", en0); end
        total++; if (r0 !== 8'hC3) begin bad++; $display("FAIL start_in_shift_rd: got %h want c3", r0); end
        push_byte(8'h96, -1, en1, acc, ok);
        pop_byte(0, r1);
        total++; if ({o_pe, r1} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL no_reload_in_shift: got %h want %h", {o_pe, r1}, {1'b1, 8'hA5}); end
        pulse_start();
        total++; if ({o_pe, o_wr_ready} !== 2'b01) begin bad++; $display("FAIL start_in_run: got %b want 01", {o_pe, o_wr_ready}); end
        push_byte(8'h11, -1, en0, acc, ok);
        pop_byte(0, r0);
        total++; if ({o_pe, o_wr_ready} !== 2'b01) begin bad++; $display("FAIL reload_mid: got %b want 01", {o_pe, o_wr_ready}); end
        push_byte(8'h22, -1, en1, acc, ok);
        pop_byte(0, r1);
        total++; if ({o_pe, r0, r1} !== {1'b1, 16'h5A96}) begin bad++; $display("FAIL reload_rd: got %h want %h", {o_pe, r0, r1}, {1'b1, 16'h5A96}); end
        total++; if (o_chain !== 16'h1122) begin bad++; $display("FAIL reload_chain: got %h want 1122", o_chain); end
    endtask

    task automatic test_random();
        int en0, en1, acc, L; bit ok0, ok1;
        logic [15:0] v, fin;
        logic [7:0]  b0, b1, r0, r1, e0, e1;
        for (int it = 0; it < 8; it++) begin
            sel = it[0];
            L = sel ? 12 : 16;
            v = 16'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin halt = 1'b1; @(negedge clk); halt = 1'b0; end
            ref_session(L, v, b0, b1, e0, e1, fin);
            preload(v);
            pulse_start();
            push_byte(b0, -1, en0, acc, ok0);
            pop_byte($urandom_range(0, 3), r0);
            push_byte(b1, -1, en1, acc, ok1);
            pop_byte($urandom_range(0, 3), r1);
            total++; if ({r0, r1} !== {e0, e1}) begin bad++; $display("FAIL rand_rd it%0d: got %h want %h", it, {r0, r1}, {e0, e1}); end
            total++; if (o_chain !== fin) begin bad++; $display("FAIL rand_chain it%0d: got %h want %h", it, o_chain, fin); end
            total++; if (en0 + en1 != L || !(ok0 & ok1)) begin bad++; $display("FAIL rand_shifts it%0d: got %0d want %0d", it, en0 + en1, L); end
            total++; if (o_pe !== 1'b1) begin bad++; $display("FAIL rand_run it%0d: got %b want 1", it, o_pe); end
        end
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; start = 1'b0; wr_data = 8'h00; wr_valid = 1'b0;
        rd_ready = 1'b0; halt = 1'b0; pre_ld = 1'b0; pre_val = 16'h0000;
        test_reset();
        test_full_load();
        test_partial();
        test_backpressure();
        test_run_halt();
        test_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
